hazard_sb: RTL
==============

HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 SHALL have parameter AW, default 5: register-address width.
REQ-002 SHALL have parameter CNTW, default 6: multi-cycle latency counter width.
REQ-003 SHALL have parameter WFWD_D, default 1: 1 enables W-to-D forwarding, 0 restricts D forwarding to M only.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports rsD, rtD  in  AW  decode source registers.
REQ-007 SHALL have ports branchD, mdopD  in  1  decode holds a branch / a multi-cycle (mult/div) op.
REQ-008 SHALL have ports rsE, rtE, writeregE  in  AW; regwriteE, memtoregE  in  1.
REQ-009 SHALL have ports mdstartE  in  1; mdwriteregE  in  AW; mdlatE  in  CNTW: multi-cycle op issue, destination, latency.
REQ-010 SHALL have ports writeregM  in  AW; regwriteM, memtoregM  in  1.
REQ-011 SHALL have ports writeregW  in  AW; regwriteW  in  1.
REQ-012 SHALL have ports i_stall, d_stall, flush_req  in  1  memory stalls, exception flush.
REQ-013 SHALL have ports forwardaD, forwardbD, forwardaE, forwardbE  out  2: 00 regfile, 01 W, 10 M, 11 multi-cycle result.
REQ-014 SHALL have ports stallF, stallD, flushD, flushE, longest_stall, mdbusy, mddone  out  1.

Function
REQ-015 SHALL compute forward selects combinationally; register 0 SHALL always give 00; priority 11 > 10 (M & regwriteM) > 01 (W & regwriteW).
REQ-016 SHALL give 11 only in state DONE when the source equals the pending destination.
REQ-017 SHALL never drive 01 on forwardaD/forwardbD when WFWD_D=0.
REQ-018 SHALL assert lwstall when memtoregE & rtE!=0 & (rtE==rsD | rtE==rtD).
REQ-019 SHALL assert brstall when branchD & ((regwriteE & writeregE matches nonzero rsD/rtD) | (memtoregM & writeregM matches nonzero rsD/rtD)).
REQ-020 SHALL implement FSM IDLE/BUSY/DONE, holding pending destination pd and down-counter cnt.
REQ-021 SHALL, in IDLE or DONE with mdstartE, latch pd=mdwriteregE and cnt=max(mdlatE,1)-1, then go BUSY if cnt!=0, else DONE.
REQ-022 SHALL, in BUSY, decrement cnt every cycle regardless of stalls and go DONE on the cycle after cnt==1.
REQ-023 SHALL remain in DONE exactly one cycle, pulsing mddone=1, then go IDLE unless REQ-021 applies.
REQ-024 SHALL ignore mdstartE in BUSY; no state change.
REQ-025 SHALL drive mdbusy=1 in BUSY only.
REQ-026 SHALL assert sbstall in BUSY when nonzero rsD or rtD equals pd.
REQ-027 SHALL assert mdstruct when mdopD & BUSY.
REQ-028 SHALL drive longest_stall = i_stall | d_stall.
REQ-029 SHALL drive stallD = lwstall | brstall | sbstall | mdstruct | longest_stall, and stallF = stallD.
REQ-030 SHALL drive flushE = flush_req | ((lwstall|brstall|sbstall|mdstruct) & ~longest_stall), so a bubble is inserted only when E advances.
REQ-031 SHALL drive flushD = flush_req.
REQ-032 SHALL, on flush_req, force next state IDLE, clear cnt and pd; flush SHALL win over a simultaneous mdstartE.

Reset
REQ-033 SHALL, while rst=1, immediately force IDLE, cnt=0, pd=0, mdbusy=0, mddone=0; combinational outputs SHALL follow from that state and the inputs.
REQ-034 SHALL, on reset mid-BUSY, discard the pending op with no mddone pulse.

Verification
REQ-035 SHALL be verified: regwriteM=1, writeregM=8, regwriteW=1, writeregW=8, rsE=8 -> forwardaE=10; with rsE=0 -> 00.
REQ-036 SHALL be verified: memtoregE=1, rtE=5, rsD=5, no memory stall -> stallF=stallD=flushE=1 for one cycle.
REQ-037 SHALL be verified: mdstartE, mdlatE=4, mdwriteregE=9, rsD=9 -> mdbusy 3 cycles, stallD=1 throughout, DONE cycle mddone=1 with forwardaE=11 when rsE=9.
REQ-038 SHALL be verified: mdlatE=0 -> DONE on the next cycle with no BUSY cycle.
REQ-039 SHALL be verified: i_stall=1 with lwstall -> stallD=1, flushE=0, longest_stall=1.
REQ-040 SHALL be verified: flush_req during BUSY with cnt=2 -> next cycle IDLE, mdbusy=0, no mddone; flushD=flushE=1.

Source files
------------

// File: rtl/hazard_sb.sv
// Hazard unit with multi-cycle scoreboard: forwarding selects, load-use and
// branch stalls, tracking of one outstanding mult/div result, stall/flush
// control.
module hazard_sb #(
   parameter int AW     = 5,
   parameter int CNTW   = 6,
   parameter int WFWD_D = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rsD,
   input  logic [AW-1:0]   rtD,
   input  logic            branchD,
   input  logic            mdopD,
   input  logic [AW-1:0]   rsE,
   input  logic [AW-1:0]   rtE,
   input  logic [AW-1:0]   writeregE,
   input  logic            regwriteE,
   input  logic            memtoregE,
   input  logic            mdstartE,
   input  logic [AW-1:0]   mdwriteregE,
   input  logic [CNTW-1:0] mdlatE,
   input  logic [AW-1:0]   writeregM,
   input  logic            regwriteM,
   input  logic            memtoregM,
   input  logic [AW-1:0]   writeregW,
   input  logic            regwriteW,
   input  logic            i_stall,
   input  logic            d_stall,
   input  logic            flush_req,
   output logic [1:0]      forwardaD,
   output logic [1:0]      forwardbD,
   output logic [1:0]      forwardaE,
   output logic [1:0]      forwardbE,
   output logic            stallF,
   output logic            stallD,
   output logic            flushD,
   output logic            flushE,
   output logic            longest_stall,
   output logic            mdbusy,
   output logic            mddone
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic W_TO_D = (WFWD_D != 0);

   state_t          state, state_n;
   logic [CNTW-1:0] cnt, cnt_n;
   logic [AW-1:0]   pd, pd_n;

   logic lwstall, brstall, sbstall, mdstruct, hz_stall;
   logic rs_pend, rt_pend;
   logic [CNTW-1:0] lat_m1;

   // Select source for one operand: multi-cycle result, then M, then W.
   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                          input logic            w_ok,
                                          input state_t          st,
                                          input logic [AW-1:0]   pdst);
      logic [1:0] sel;
      sel = 2'b00;
      if (src != '0) begin
         if (st == DONE && src == pdst)
            sel = 2'b11;
         else if (regwriteM && writeregM == src)
            sel = 2'b10;
         else if (w_ok && regwriteW && writeregW == src)
            sel = 2'b01;
      end
      return sel;
   endfunction

   // Scoreboard state register: pending destination and remaining latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         pd    <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         pd    <= pd_n;
      end
   end

   // Latency of 0 is treated as 1; counter holds cycles left after issue.
   assign lat_m1 = (mdlatE == '0) ? '0 : mdlatE - CNTW'(1);

   // Next-state: issue from IDLE/DONE, count down in BUSY, flush overrides.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pd_n    = pd;
      case (state)
         IDLE, DONE: begin
            if (mdstartE) begin
               pd_n    = mdwriteregE;
               cnt_n   = lat_m1;
               state_n = (lat_m1 != '0) ? BUSY : DONE;
            end else begin
               state_n = IDLE;
            end
         end
         BUSY: begin
            cnt_n = (cnt == '0) ? '0 : cnt - CNTW'(1);
            if (cnt <= CNTW'(1))
               state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
      if (flush_req) begin
         state_n = IDLE;
         cnt_n   = '0;
         pd_n    = '0;
      end
   end

   // Forwarding selects for decode (W path optional) and execute operands.
   always_comb begin
      forwardaD = fwd_sel(rsD, W_TO_D, state, pd);
      forwardbD = fwd_sel(rtD, W_TO_D, state, pd);
      forwardaE = fwd_sel(rsE, 1'b1, state, pd);
      forwardbE = fwd_sel(rtE, 1'b1, state, pd);
   end

   assign rs_pend  = (rsD != '0) && (rsD == pd);
   assign rt_pend  = (rtD != '0) && (rtD == pd);

   assign lwstall  = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
   assign brstall  = branchD &&
                     ((regwriteE && (writeregE != '0) &&
                       ((writeregE == rsD) || (writeregE == rtD))) ||
                      (memtoregM && (writeregM != '0) &&
                       ((writeregM == rsD) || (writeregM == rtD))));
   assign sbstall  = (state == BUSY) && (rs_pend || rt_pend);
   assign mdstruct = mdopD && (state == BUSY);
   assign hz_stall = lwstall | brstall | sbstall | mdstruct;

   assign longest_stall = i_stall | d_stall;
   assign stallD        = hz_stall | longest_stall;
   assign stallF        = stallD;
   // Bubble into E only when E actually advances (no memory stall).
   assign flushE        = flush_req | (hz_stall & ~longest_stall);
   assign flushD        = flush_req;

   assign mdbusy = (state == BUSY);
   assign mddone = (state == DONE);

endmodule
